// File: rtl/addsub_acc.sv
// Accumulating front end for the addsub datapath: a valid/ready op stream updates
// an accumulator, and each result is captured with flags in a one-entry output buffer.

module addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add_sub,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH:0] full;

  // The extra top bit is the carry-out on add and the borrow on subtract.
  always_comb begin
    if (add_sub) full = {1'b0, a} + {1'b0, b};
    else         full = {1'b0, a} - {1'b0, b};
    y     = full[WIDTH-1:0];
    carry = full[WIDTH];
    if (add_sub) overflow = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
    else         overflow = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
  end
endmodule

module addsub_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] acc,
  output logic [7:0]       count
);
  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  op_e op_s;
  assign op_s = op_e'(op);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       count_q, count_d;

  logic [WIDTH-1:0] as_y;
  logic             as_carry;
  logic             as_overflow;
  logic             accept;

  addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (acc_q),
    .b        (operand),
    .add_sub  (op_s != OP_SUB),
    .y        (as_y),
    .carry    (as_carry),
    .overflow (as_overflow)
  );

  // A full buffer frees up in the same cycle the consumer takes it.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: every signal gets a hold default first so no path through this block infers a latch.
  always_comb begin
    acc_d       = acc_q;
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;

    if (accept) begin
      out_valid_d = 1'b1;
      count_d     = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
      unique case (op_s)
        OP_CLR: begin
          acc_d      = '0;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          count_d    = 8'd1;
        end
        OP_LOAD: begin
          acc_d      = operand;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
        end
        OP_ADD, OP_SUB: begin
          acc_d      = as_y;
          carry_d    = as_carry;
          overflow_d = as_overflow;
        end
        default: ;
      endcase
      result_d = acc_d;
      zero_d   = (acc_d == '0);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      acc_q       <= acc_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign acc       = acc_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
endmodule

// File: doc/addsub_acc.md
# addsub_acc

Accumulating front end for the `addsub` datapath: takes a stream of opcode/operand pairs over a valid/ready handshake and applies each to an internal WIDTH-bit accumulator. It drives `addsub` with the accumulator and the operand, then registers the result with carry, overflow and zero flags into a single-entry output buffer with backpressure. It sits directly upstream of `addsub` and owns its operand and `add_sub` inputs.

## Interface

- `WIDTH`, 8, datapath width of the accumulator, operand and result.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream has an op this cycle.
- `in_ready`  out  1  block can accept an op this cycle.
- `op`  in  2  00 CLR, 01 LOAD, 10 ADD, 11 SUB.
- `operand`  in  WIDTH  operand for LOAD/ADD/SUB; ignored for CLR.
- `out_valid`  out  1  output buffer holds an unconsumed result.
- `out_ready`  in  1  downstream consumes the result this cycle.
- `result`  out  WIDTH  accumulator value after the buffered op.
- `carry`  out  1  ADD: unsigned carry-out. SUB: borrow (acc < operand, unsigned).
- `overflow`  out  1  signed two's-complement overflow of the buffered op.
- `zero`  out  1  `result == 0`.
- `acc`  out  WIDTH  live accumulator register.
- `count`  out  8  number of accepted ops since reset or the last CLR; saturates at 255.

## Operation

- Accept condition: `in_valid && in_ready`. `in_ready = !out_valid || out_ready` (combinational; no dependence on `in_valid`).
- On accept, all of the following update on the same edge:
  - `acc`, and the buffer (`result`/`carry`/`overflow`/`zero`) from the new value.
  - `out_valid <= 1`.
  - `count <= min(count+1, 255)`.
- Per-op arithmetic, with `a` the old `acc` and `b` the operand:
  - ADD: `addsub` with `add_sub=1`. `{carry,new} = a + b` at WIDTH+1 bits. `overflow = (a[W-1]==b[W-1]) && (new[W-1]!=a[W-1])`.
  - SUB: `addsub` with `add_sub=0`. `new = (a - b) mod 2^WIDTH`. `carry = (a < b)` unsigned. `overflow = (a[W-1]!=b[W-1]) && (new[W-1]!=a[W-1])`.
  - LOAD: `new = b`. `carry=0`, `overflow=0`.
  - CLR: `new = 0`. `carry=0`, `overflow=0`. `count <= 1` (the CLR itself is counted).
  - `zero = (new == 0)` for every op.
- Buffer drain: `out_valid && out_ready` with no accept clears `out_valid`. `result` and the flags hold their last values.
- Simultaneous drain and accept: buffer overwritten with the new op; `out_valid` stays 1.
- No accept: `acc`, `count`, buffer and flags hold.
- Stall: while `out_valid && !out_ready`, `in_ready=0`. Upstream must hold `op`/`operand` stable; the accumulator does not change.
- Reset (async, any time, including mid-stall):
  - `acc=0`, `result=0`, `carry=0`, `overflow=0`, `zero=0`, `out_valid=0`, `count=0`.
  - `in_ready` = 1 immediately.
  - A pending unconsumed result is discarded.

## Timing

- Latency: op accepted at edge N; `result`/flags/`out_valid` valid after edge N and consumable in cycle N+1.
- Throughput: one op per cycle while `out_ready=1`.
- `acc` after edge N always equals `result` of the most recent accepted op.
- No combinational path from `in_valid`/`op`/`operand` to any output. `out_ready -> in_ready` is the only combinational path.

## Test plan

- Reset and basic ops: assert `reset` then release; expect all outputs 0 and `in_ready=1`. Then LOAD 9, SUB 2 -> `result=7`, `carry=0`, `overflow=0`, `zero=0`, `count=2`.
- Add wrap and zero flag: LOAD 3, ADD 2 -> `result=5`. Then ADD 251 -> `result=0`, `carry=1`, `zero=1`, `overflow=0`.
- Borrow and signed overflow:
  - LOAD 9, SUB 10 -> `result=255`, `carry=1`, `overflow=0`.
  - LOAD 127, ADD 1 -> `result=128`, `overflow=1`, `carry=0`.
  - LOAD 128, SUB 1 -> `result=127`, `overflow=1`.
- Back-to-back with `out_ready=1`: CLR, then ADD 1 ×4 on consecutive cycles -> `out_valid` high 5 cycles, results 0,1,2,3,4, `count=5`.
- Backpressure: with `out_ready=0` and a result buffered, hold `in_valid=1`, ADD 5 for 3 cycles -> `in_ready=0`, `acc` and `result` unchanged. Raise `out_ready` -> ADD accepted that same cycle, `result` = old+5.
- Async reset mid-stall: buffer full, `out_ready=0`. Pulse `reset` between clock edges -> `out_valid`, `acc`, `count` read 0 before the next edge, and `in_ready=1`.
